// File: rtl/pwm_pkg.sv
// Shared PWM definitions: duty width, mid-scale value, the ramp FSM state
// type and the command-to-duty helper functions.
package pwm_pkg;

    localparam int DUTY_W = 12;
    localparam logic [DUTY_W-1:0] DUTY_MID = 12'h800;

    // Default slew step and clamp limits for the duty feeder.
    localparam logic [DUTY_W-1:0] DEF_STEP     = 12'h010;
    localparam logic [DUTY_W-1:0] DEF_MIN_DUTY = 12'h040;
    localparam logic [DUTY_W-1:0] DEF_MAX_DUTY = 12'hFC0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RAMP = 2'd2
    } ramp_state_t;

    // Two's complement command to offset binary: flipping the sign bit adds 2048.
    function automatic logic [DUTY_W-1:0] to_offset_bin(input logic [DUTY_W-1:0] cmd);
        return {~cmd[DUTY_W-1], cmd[DUTY_W-2:0]};
    endfunction

    // Saturate an offset-binary duty into [lo, hi].
    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] raw,
                                                     input logic [DUTY_W-1:0] lo,
                                                     input logic [DUTY_W-1:0] hi);
        if (raw < lo)
            return lo;
        else if (raw > hi)
            return hi;
        else
            return raw;
    endfunction

endpackage

// File: rtl/duty_slew.sv
// Registered duty with slew limiting: on each enabled step the duty moves
// toward the target by at most STEP and lands exactly on it when closer.
// jump_mid forces the duty straight to mid-scale with no slew limit.
module duty_slew
    import pwm_pkg::*;
#(
    parameter logic [DUTY_W-1:0] STEP = DEF_STEP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step_en,
    input  logic              jump_mid,
    input  logic [DUTY_W-1:0] target,
    output logic [DUTY_W-1:0] duty,
    output logic [DUTY_W-1:0] duty_nxt
);

    logic signed [DUTY_W:0] diff;
    logic signed [DUTY_W:0] step_s;

    // One extra bit keeps the unsigned difference free of wrap-around.
    assign step_s = $signed({1'b0, STEP});
    assign diff   = $signed({1'b0, target}) - $signed({1'b0, duty});

    // Next duty: a full step toward the target, or the target itself when within one step.
    always_comb begin
        duty_nxt = duty;
        if (jump_mid) begin
            duty_nxt = DUTY_MID;
        end else if (step_en) begin
            if (diff > step_s)
                duty_nxt = duty + STEP;
            else if (diff < -step_s)
                duty_nxt = duty - STEP;
            else
                duty_nxt = target;
        end
    end

    // Duty register, returns to mid-scale on reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst)
            duty <= DUTY_MID;
        else
            duty <= duty_nxt;
    end

endmodule

// File: rtl/duty_ramp.sv
// Upstream feeder of the 12-bit PWM generator. Accepts signed commands over
// valid/ready, converts and clamps them to an offset-binary target, and lets
// duty_slew walk the duty toward it one step per PWM period (synch pulse).
// Optional build macro DUTY_RAMP_BRAKE_EN adds a brake input that forces the
// target to mid-scale and snaps the duty there on the next synch.
module duty_ramp
    import pwm_pkg::*;
#(
    parameter logic [DUTY_W-1:0] STEP     = DEF_STEP,
    parameter logic [DUTY_W-1:0] MIN_DUTY = DEF_MIN_DUTY,
    parameter logic [DUTY_W-1:0] MAX_DUTY = DEF_MAX_DUTY
) (
    input  logic              clk,
    input  logic              rst,
`ifdef DUTY_RAMP_BRAKE_EN
    input  logic              brake,
`endif
    input  logic              synch,
    input  logic [DUTY_W-1:0] cmd,
    input  logic              cmd_vld,
    output logic              cmd_rdy,
    output logic [DUTY_W-1:0] duty,
    output logic              at_target
);

    ramp_state_t       state, state_nxt;
    logic [DUTY_W-1:0] target;
    logic [DUTY_W-1:0] cmd_q;
    logic [DUTY_W-1:0] new_target;
    logic [DUTY_W-1:0] duty_nxt;
    logic              brake_act;
    logic              xfer;

`ifdef DUTY_RAMP_BRAKE_EN
    assign brake_act = brake;
`else
    assign brake_act = 1'b0;
`endif

    assign cmd_rdy    = (state != LOAD) && !brake_act;
    assign xfer       = cmd_vld && cmd_rdy;
    assign new_target = clamp_duty(to_offset_bin(cmd_q), MIN_DUTY, MAX_DUTY);
    assign at_target  = (duty == target) && (state != LOAD);

    // Next-state logic: accept commands, load the target, ramp until the duty lands on it.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path infers a latch.
        state_nxt = state;
        case (state)
            IDLE: begin
                if (xfer)
                    state_nxt = LOAD;
            end
            LOAD: begin
                // Compare against the post-edge duty so a coincident synch step is accounted for.
                state_nxt = (new_target != duty_nxt) ? RAMP : IDLE;
            end
            RAMP: begin
                if (xfer)
                    state_nxt = LOAD;
                else if (duty_nxt == target)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (brake_act)
            state_nxt = IDLE;
    end

    // State, captured command and target registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cmd_q  <= '0;
            target <= DUTY_MID;
        end else begin
            state <= state_nxt;
            if (xfer)
                cmd_q <= cmd;
            if (brake_act)
                target <= DUTY_MID;
            else if (state == LOAD)
                target <= new_target;
        end
    end

    duty_slew #(
        .STEP(STEP)
    ) u_slew (
        .clk     (clk),
        .rst     (rst),
        .step_en (synch && (state != IDLE)),
        .jump_mid(synch && brake_act),
        .target  (target),
        .duty    (duty),
        .duty_nxt(duty_nxt)
    );

endmodule

// File: tb/tb_duty_ramp.sv
// Self-checking bench for duty_ramp: a directed vector table, hand-written
// corner sequences and a randomized phase against a period-level model.
module tb_duty_ramp;

    logic        clk = 1'b0;
    logic        rst;
    logic        synch;
    logic [11:0] cmd;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic [11:0] duty;
    logic        at_target;
`ifdef DUTY_RAMP_BRAKE_EN
    logic        brake = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Model state: duty and target as plain integers, plus a pending load.
    int m_duty;
    int m_target;
    int m_pend;
    bit m_loading;

    typedef struct {
        logic        s;
        logic        v;
        logic [11:0] c;
        logic [11:0] e_duty;
        logic        e_rdy;
        logic        e_at;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    duty_ramp dut (
        .clk      (clk),
        .rst      (rst),
`ifdef DUTY_RAMP_BRAKE_EN
        .brake    (brake),
`endif
        .synch    (synch),
        .cmd      (cmd),
        .cmd_vld  (cmd_vld),
        .cmd_rdy  (cmd_rdy),
        .duty     (duty),
        .at_target(at_target)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Signed command value shifted to offset binary, then saturated.
    function automatic int model_target(input logic [11:0] c);
        int v;
        v = int'($signed(c)) + 2048;
        if (v < 64)   v = 64;
        if (v > 4032) v = 4032;
        return v;
    endfunction

    task automatic model_reset();
        m_duty    = 2048;
        m_target  = 2048;
        m_pend    = 2048;
        m_loading = 1'b0;
    endtask

    // Apply one cycle of inputs, advance the model by the same edge, sample at negedge.
    task automatic drive(input logic s, input logic v, input logic [11:0] c);
        bit x;
        synch   = s;
        cmd_vld = v;
        cmd     = c;
        @(posedge clk);
        x = v && !m_loading;
        if (s && m_duty != m_target) begin
            if (m_target > m_duty)
                m_duty += (m_target - m_duty > 16) ? 16 : (m_target - m_duty);
            else
                m_duty -= (m_duty - m_target > 16) ? 16 : (m_duty - m_target);
        end
        if (m_loading)
            m_target = m_pend;
        m_loading = x;
        if (x)
            m_pend = model_target(c);
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_duty"}, 32'(duty), 32'(m_duty));
        check({tag, "_rdy"}, 32'(cmd_rdy), 32'(!m_loading));
        check({tag, "_at"}, 32'(at_target), 32'((m_duty == m_target) && !m_loading));
    endtask

    // Synch every cycle until the duty settles; a timeout shows up as at_target=0.
    task automatic ramp_done(input string name, input logic [11:0] exp_duty);
        for (int i = 0; i < 600; i++) begin
            if (at_target && cmd_rdy)
                break;
            drive(1'b1, 1'b0, 12'h000);
        end
        check({name, "_duty"}, 32'(duty), 32'(exp_duty));
        check({name, "_at"}, 32'(at_target), 32'd1);
    endtask

    initial begin
        rst     = 1'b1;
        synch   = 1'b0;
        cmd     = '0;
        cmd_vld = 1'b0;
        model_reset();

        // {synch, vld, cmd, duty, cmd_rdy, at_target} after each edge
        vecs[0] = '{1'b1, 1'b0, 12'h000, 12'h800, 1'b1, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 12'h000, 12'h800, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 12'h000, 12'h800, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 12'h000, 12'h800, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 12'h100, 12'h800, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 12'h000, 12'h800, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 12'h000, 12'h810, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 12'h000, 12'h810, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 12'h000, 12'h820, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_duty", 32'(duty), 32'h800);
        check("rst_rdy", 32'(cmd_rdy), 32'd1);
        check("rst_at", 32'(at_target), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Idle synchs, first command and the start of its ramp
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].s, vecs[i].v, vecs[i].c);
            check($sformatf("vec%0d_duty", i), 32'(duty), 32'(vecs[i].e_duty));
            check($sformatf("vec%0d_rdy", i), 32'(cmd_rdy), 32'(vecs[i].e_rdy));
            check($sformatf("vec%0d_at", i), 32'(at_target), 32'(vecs[i].e_at));
        end

        // Remaining 14 synchs of the ramp to 12'h900
        for (int k = 1; k <= 14; k++) begin
            drive(1'b1, 1'b0, 12'h000);
            check($sformatf("ramp900_%0d", k), 32'(duty), 32'h820 + 32'(16 * k));
            check($sformatf("ramp900_at_%0d", k), 32'(at_target), 32'(k == 14));
        end

        // Clamp limits
        drive(1'b0, 1'b1, 12'h7FF);
        ramp_done("clamp_hi", 12'hFC0);
        drive(1'b0, 1'b1, 12'h800);
        ramp_done("clamp_lo", 12'h040);

        // Retarget mid-ramp at duty 12'h880
        drive(1'b0, 1'b1, 12'h200);
        for (int i = 0; i < 300; i++) begin
            if (duty == 12'h880)
                break;
            drive(1'b1, 1'b0, 12'h000);
        end
        check("retgt_at880", 32'(duty), 32'h880);
        check("retgt_rdy_before", 32'(cmd_rdy), 32'd1);
        drive(1'b0, 1'b1, 12'hF00);
        check("retgt_rdy_load", 32'(cmd_rdy), 32'd0);
        check("retgt_at_load", 32'(at_target), 32'd0);
        drive(1'b0, 1'b0, 12'h000);
        check("retgt_rdy_after", 32'(cmd_rdy), 32'd1);
        check("retgt_hold", 32'(duty), 32'h880);
        drive(1'b1, 1'b0, 12'h000);
        check("retgt_step", 32'(duty), 32'h870);
        ramp_done("retgt_end", 12'h700);

        // No overshoot on the last partial step
        drive(1'b0, 1'b1, 12'h005);
        ramp_done("to805", 12'h805);
        drive(1'b0, 1'b1, 12'h00C);
        drive(1'b0, 1'b0, 12'h000);
        drive(1'b1, 1'b0, 12'h000);
        check("nover_duty", 32'(duty), 32'h80C);
        check("nover_at", 32'(at_target), 32'd1);

        // Reset mid-ramp, with a further command pending in LOAD
        drive(1'b0, 1'b1, 12'h400);
        drive(1'b0, 1'b0, 12'h000);
        repeat (5) drive(1'b1, 1'b0, 12'h000);
        check("pre_rst_duty", 32'(duty), 32'h85C);
        drive(1'b0, 1'b1, 12'h7FF);
        #2 rst = 1'b1;
        #1;
        check("midrst_duty", 32'(duty), 32'h800);
        check("midrst_rdy", 32'(cmd_rdy), 32'd1);
        check("midrst_at", 32'(at_target), 32'd1);
        cmd_vld = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) drive(1'b1, 1'b0, 12'h000);
        check("post_rst_duty", 32'(duty), 32'h800);
        check("post_rst_at", 32'(at_target), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            logic [11:0] c;
            c = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 4095))
                                            : 12'($urandom_range(0, 255)) - 12'd128;
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0, c);
            check_model("rand");
        end

`ifdef DUTY_RAMP_BRAKE_EN
        // Brake snaps the duty to mid-scale on the next synch
        drive(1'b0, 1'b1, 12'h400);
        ramp_done("brk_pre", 12'hC00);
        brake = 1'b1;
        #1;
        check("brk_rdy", 32'(cmd_rdy), 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 12'h000);
        check("brk_hold", 32'(duty), 32'hC00);
        drive(1'b1, 1'b0, 12'h000);
        check("brk_duty", 32'(duty), 32'h800);
        check("brk_at", 32'(at_target), 32'd1);
        brake = 1'b0;
        #1;
        check("brk_rel_rdy", 32'(cmd_rdy), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
